dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Single-port arbiter and controller for the pipeline's 128-word × 64-bit data memory. It shares the memory between two requesters: the pipeline memory stage (port M) and the program loader/debug port (port D). It owns the storage array, sequences each access through a two-state FSM and returns read data with an address-error flag. Port M's error flag drives the memory stage's ADR status (stat = 2'b10).

## Interface
- DEPTH, 128, number of 64-bit words; legal addresses are 0..DEPTH-1
- DW, 64, data width
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- m_req  in  1  port M request; held with its command until m_gnt is seen
- m_we  in  1  1 = write, 0 = read (pushq/call/rmmovq write; popq/ret/mrmovq read)
- m_addr  in  64  word address (valE or valA from the memory stage)
- m_wdata  in  DW  write data (valA)
- m_gnt  out  1  one-cycle pulse: the port M command is being executed
- m_done  out  1  one-cycle pulse, cycle after m_gnt: m_rdata and m_err are valid
- m_rdata  out  DW  read data; 0 on write or error
- m_err  out  1  address out of range (valid with m_done)
- d_req, d_we, d_addr, d_wdata, d_gnt, d_done, d_rdata, d_err: identical semantics for port D

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, no request: stay in IDLE.
- IDLE, any request: latch the winner's we/addr/wdata and winner id, then go to ACCESS.
- ACCESS: execute the latched command, then return to IDLE unconditionally.
- Arbitration is round-robin, using register last (0 = M, 1 = D):
  - Only one request: that port wins.
  - Both request: the port not equal to last wins.
  - last updates to the winner when the command is latched.
  - Reset sets last = D, so M wins the first tie.
- Access in ACCESS, with addr < DEPTH:
  - Write: array[addr] <= wdata; rdata <= 0; err <= 0.
  - Read: rdata <= array[addr]; err <= 0.
- Access in ACCESS, with addr ≥ DEPTH (full 64-bit compare, no truncation or wrap): no array write; rdata <= 0; err <= 1.
- Only the winner's gnt/done/rdata/err change. The loser's rdata and err hold their previous values.
- Requester rule: drop req (or present a new command) in the cycle after gnt. The arbiter does not re-sample req during ACCESS.
- Array contents are not cleared by reset. Initial contents come from the team's data-memory image file.
- Reset values: state = IDLE, last = D, all gnt/done/err = 0, all rdata = 0.

## Timing
- Cycle T (IDLE): req sampled high. At the edge ending T the command is latched.
- T+1 (ACCESS): gnt = 1 for the winner (registered). At the edge ending T+1 the array is written or read.
- T+2 (IDLE): done = 1 with rdata/err valid. A new request present in T+2 is sampled, giving gnt at T+3.
- Latency: req to gnt is 1 cycle; req to done is 2 cycles.
- Throughput: one access every 2 cycles with a single requester.
- With both ports saturated, accesses alternate M, D, M, D, …. Each port waits at most 4 cycles from req to gnt.
- Read-after-write to the same address in consecutive accesses returns the new data. The write completes before the next ACCESS.
- Reset asserted during ACCESS:
  - The write is suppressed.
  - No done pulse is issued.
  - The next cycle is IDLE with all outputs at reset values.
- Reset takes priority over every other event in the same cycle.

## Test plan
- Reset then M write: m_we = 1, m_addr = 5, m_wdata = 0xDEADBEEF_00000001. Expect m_gnt at T+1 and m_done at T+2 with m_err = 0. A following M read of addr 5 returns 0xDEADBEEF_00000001.
- Simultaneous reads: m_req and d_req both high on the first cycle after reset. Expect M granted first, D granted at T+3. Holding both requests continuously gives the grant order M, D, M, D.
- Boundary addresses:
  - Read addr 127: m_err = 0.
  - Write addr 128 with wdata = 0x55: m_err = 1, m_rdata = 0.
  - Write addr 0xFFFF_FFFF_FFFF_FF80: m_err = 1.
  - Word 0 is unchanged after both bad writes (no wrap).
- Reset mid-op: D write to addr 10 with wdata = 0x1234, reset pulsed during ACCESS. Expect no d_done and all outputs 0 next cycle. A later read of addr 10 returns the pre-test value.
- Loser isolation: M read of addr 3 completes (m_rdata = array[3]), then D performs an erroring write to addr 200. Expect m_rdata and m_err unchanged while d_err = 1.
- Idle stability: no requests for 20 cycles. Expect all gnt/done to stay 0 and state to remain IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin arbiter and controller that shares a single-port
//            128 x 64-bit data memory between the pipeline (M) and loader (D).
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DEPTH = 128,
  parameter int DW    = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [63:0]   m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic          m_gnt,
  output logic          m_done,
  output logic [DW-1:0] m_rdata,
  output logic          m_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [63:0]   d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_err
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [63:0] DEPTH_W = 64'(DEPTH);
  localparam logic        ID_M    = 1'b0;
  localparam logic        ID_D    = 1'b1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic [63:0]   addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          m_gnt_q, m_gnt_d, d_gnt_q, d_gnt_d;
  logic          m_done_q, m_done_d, d_done_q, d_done_d;
  logic          m_err_q, m_err_d, d_err_q, d_err_d;
  logic [DW-1:0] m_rdata_q, m_rdata_d, d_rdata_q, d_rdata_d;

  logic [DW-1:0] mem [DEPTH];

  logic          win;
  logic          in_range;
  logic          mem_wr;
  logic [DW-1:0] acc_rdata;

  always_comb begin
    // D wins when alone, or on a tie when M was served last.
    win       = d_req & (~m_req | ~last_q);
    // Full-width compare so huge addresses never alias onto low words.
    in_range  = (addr_q < DEPTH_W);
    acc_rdata = (in_range && !we_q) ? mem[addr_q[AW-1:0]] : '0;
    mem_wr    = 1'b0;

    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    m_done_d  = 1'b0;
    d_done_d  = 1'b0;
    m_err_d   = m_err_q;
    d_err_d   = d_err_q;
    m_rdata_d = m_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (m_req || d_req) begin
          state_d = S_ACCESS;
          last_d  = win;
          id_d    = win;
          we_d    = win ? d_we    : m_we;
          addr_d  = win ? d_addr  : m_addr;
          wdata_d = win ? d_wdata : m_wdata;
          m_gnt_d = (win == ID_M);
          d_gnt_d = (win == ID_D);
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        mem_wr  = in_range & we_q;
        if (id_q == ID_M) begin
          m_done_d  = 1'b1;
          m_rdata_d = acc_rdata;
          m_err_d   = ~in_range;
        end else begin
          d_done_d  = 1'b1;
          d_rdata_d = acc_rdata;
          d_err_d   = ~in_range;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= ID_D;
      id_q      <= ID_M;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      m_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      m_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      m_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      m_gnt_q   <= m_gnt_d;
      d_gnt_q   <= d_gnt_d;
      m_done_q  <= m_done_d;
      d_done_q  <= d_done_d;
      m_err_q   <= m_err_d;
      d_err_q   <= d_err_d;
      m_rdata_q <= m_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Storage is never cleared; reset only blocks a write in flight.
  always_ff @(posedge clock) begin
    if (!reset && mem_wr) begin
      mem[addr_q[AW-1:0]] <= wdata_q;
    end
  end

  assign m_gnt   = m_gnt_q;
  assign m_done  = m_done_q;
  assign m_rdata = m_rdata_q;
  assign m_err   = m_err_q;
  assign d_gnt   = d_gnt_q;
  assign d_done  = d_done_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m_req = 1'b0, m_we = 1'b0;
  logic [63:0] m_addr = '0, m_wdata = '0;
  logic        m_gnt, m_done, m_err;
  logic [63:0] m_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [63:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_done, d_err;
  logic [63:0] d_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.DEPTH(128), .DW(64)) dut (
    .clock   (clock),
    .reset   (reset),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_gnt   (m_gnt),
    .m_done  (m_done),
    .m_rdata (m_rdata),
    .m_err   (m_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_done  (d_done),
    .d_rdata (d_rdata),
    .d_err   (d_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_gnt"},   m_gnt,   0);
    check({tag, "_m_done"},  m_done,  0);
    check({tag, "_m_rdata"}, m_rdata, 0);
    check({tag, "_m_err"},   m_err,   0);
    check({tag, "_d_gnt"},   d_gnt,   0);
    check({tag, "_d_done"},  d_done,  0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_d_err"},   d_err,   0);
  endtask

  // One complete access on a single port: gnt one cycle after req, done the next.
  task automatic access(input bit port, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rdata,
                        input bit exp_err, input string tag);
    if (port == 1'b0) begin
      m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end
    tick();
    if (port == 1'b0) begin
      check({tag, "_m_gnt"}, m_gnt, 1);
      check({tag, "_d_gnt"}, d_gnt, 0);
      m_req = 1'b0;
    end else begin
      check({tag, "_d_gnt"}, d_gnt, 1);
      check({tag, "_m_gnt"}, m_gnt, 0);
      d_req = 1'b0;
    end
    tick();
    if (port == 1'b0) begin
      check({tag, "_m_done"},  m_done,  1);
      check({tag, "_m_rdata"}, m_rdata, exp_rdata);
      check({tag, "_m_err"},   m_err,   {63'd0, exp_err});
      check({tag, "_d_done"},  d_done,  0);
    end else begin
      check({tag, "_d_done"},  d_done,  1);
      check({tag, "_d_rdata"}, d_rdata, exp_rdata);
      check({tag, "_d_err"},   d_err,   {63'd0, exp_err});
      check({tag, "_m_done"},  m_done,  0);
    end
  endtask

  initial begin
    // Reset and verify every output is at its reset value.
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Both ports saturated from the first cycle after reset: M first, then D.
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'd0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("sat_m_gnt", m_gnt, (k == 1 || k == 5));
      check("sat_d_gnt", d_gnt, (k == 3 || k == 7));
      if (k == 8) begin
        m_req = 1'b0;
        d_req = 1'b0;
      end
    end
    tick();

    // Write then read back on port M.
    access(1'b0, 1'b1, 64'd5, 64'hDEADBEEF_00000001, 64'd0, 1'b0, "wr5");
    access(1'b0, 1'b0, 64'd5, 64'd0, 64'hDEADBEEF_00000001, 1'b0, "rd5");

    // Boundary addresses; word 0 must survive two out-of-range writes.
    access(1'b0, 1'b1, 64'd0, 64'h0000_0000_0000_A5A5, 64'd0, 1'b0, "wr0");
    access(1'b0, 1'b1, 64'd127, 64'h7F7F, 64'd0, 1'b0, "wr127");
    access(1'b0, 1'b0, 64'd127, 64'd0, 64'h7F7F, 1'b0, "rd127");
    access(1'b0, 1'b1, 64'd128, 64'h55, 64'd0, 1'b1, "wr128");
    access(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 64'h66, 64'd0, 1'b1, "wrhuge");
    access(1'b0, 1'b0, 64'd0, 64'd0, 64'h0000_0000_0000_A5A5, 1'b0, "rd0");

    // Reset during a D write: write suppressed, no done, outputs cleared.
    access(1'b1, 1'b1, 64'd10, 64'h1111, 64'd0, 1'b0, "pre10");
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd10; d_wdata = 64'h1234;
    tick();
    check("rstmid_d_gnt", d_gnt, 1);
    d_req = 1'b0;
    reset = 1'b1;
    tick();
    check_all_zero("rstmid");
    reset = 1'b0;
    tick();
    check("rstmid_d_done_late", d_done, 0);
    access(1'b1, 1'b0, 64'd10, 64'd0, 64'h1111, 1'b0, "rd10");

    // Loser isolation: D error must not disturb M's results.
    access(1'b0, 1'b1, 64'd3, 64'h3333, 64'd0, 1'b0, "wr3");
    access(1'b0, 1'b0, 64'd3, 64'd0, 64'h3333, 1'b0, "rd3");
    access(1'b1, 1'b1, 64'd200, 64'h99, 64'd0, 1'b1, "dwr200");
    check("iso_m_rdata", m_rdata, 64'h3333);
    check("iso_m_err",   m_err,   0);

    // Idle stability, then a normal access proves the FSM is still in IDLE.
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_m_gnt",  m_gnt,  0);
      check("idle_d_gnt",  d_gnt,  0);
      check("idle_m_done", m_done, 0);
      check("idle_d_done", d_done, 0);
    end
    access(1'b0, 1'b0, 64'd5, 64'd0, 64'hDEADBEEF_00000001, 1'b0, "post_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
